program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 33 +++
 rtl/program_loader_if.sv | 23 ++
 rtl/loader_timeout.sv | 30 +++
 rtl/program_loader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and frame-field widths for the serial program loader.
package program_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 9;
    localparam int BUS_W  = 16;
    localparam int TMO_W  = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA_WAIT,
        ST_SET_MAR,
        ST_WRITE_M,
        ST_DONE
    } loader_state_t;

    // States in which a byte may be taken from the receiver
    function automatic logic is_rx_state(loader_state_t s);
        return s inside {ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_LEN, ST_DATA_WAIT};
    endfunction

    // States in which the inter-byte idle limit is enforced
    function automatic logic is_timed_state(loader_state_t s);
        return s inside {ST_ADDR_HI, ST_ADDR_LO, ST_LEN, ST_DATA_WAIT};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory-controller bus signals of the program loader.
interface program_loader_if;
    import program_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BUS_W-1:0]  bus_out;
    logic              bus_oe;
    logic              set_mar;
    logic              write_m;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, bus_out, bus_oe, set_mar, write_m
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, bus_out, bus_oe, set_mar, write_m
    );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: counts while run is high, flags the last allowed cycle.
module loader_timeout
    import program_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && count != LIMIT) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Receives SYNC/ADDR/LEN/data frames from a byte stream and replays each data
// byte as a SET_MAR + WRITE_M pair on the memory-controller bus.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 50000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    program_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t     state;
    logic [ADDR_W-1:0] address;
    logic [BYTE_W-1:0] data;
    logic [CNT_W-1:0]  remaining;
    logic              set_mar_q;
    logic              write_m_q;
    logic              done_q;
    logic [BUS_W-1:0]  bus_q;
    logic              accept;
    logic              timed;
    logic              expired;
    logic              timeout_hit;

    // reset gates rx_ready so no byte is offered a handshake while held in reset
    assign bus.rx_ready = reset && enable && is_rx_state(state);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign timed        = enable && is_timed_state(state);
    assign timeout_hit  = expired && !accept;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || !timed),
        .run    (timed),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            address   <= '0;
            data      <= '0;
            remaining <= '0;
            set_mar_q <= 1'b0;
            write_m_q <= 1'b0;
            done_q    <= 1'b0;
            bus_q     <= '0;
        end else begin
            set_mar_q <= 1'b0;
            write_m_q <= 1'b0;
            done_q    <= 1'b0;
            bus_q     <= '0;
            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && bus.rx_data == SYNC_BYTE) state <= ST_ADDR_HI;
                    end
                    ST_ADDR_HI: begin
                        if (accept) begin
                            address[15:8] <= bus.rx_data;
                            state         <= ST_ADDR_LO;
                        end else if (timeout_hit) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ADDR_LO: begin
                        if (accept) begin
                            address[7:0] <= bus.rx_data;
                            state        <= ST_LEN;
                        end else if (timeout_hit) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_LEN: begin
                        if (accept) begin
                            remaining <= (bus.rx_data == '0) ? CNT_W'(256) : CNT_W'(bus.rx_data);
                            state     <= ST_DATA_WAIT;
                        end else if (timeout_hit) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA_WAIT: begin
                        if (accept) begin
                            data      <= bus.rx_data;
                            set_mar_q <= 1'b1;
                            bus_q     <= address;
                            state     <= ST_SET_MAR;
                        end else if (timeout_hit) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_SET_MAR: begin
                        write_m_q <= 1'b1;
                        bus_q     <= {8'h00, data};
                        state     <= ST_WRITE_M;
                    end
                    ST_WRITE_M: begin
                        address   <= address + ADDR_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_DATA_WAIT;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Strobes are registered but dropped combinationally the moment enable falls
    assign bus.set_mar = enable && set_mar_q;
    assign bus.write_m = enable && write_m_q;
    assign bus.bus_oe  = enable && (set_mar_q || write_m_q);
    assign bus.bus_out = enable ? bus_q : '0;
    assign done        = enable && done_q;
    assign error       = timeout_hit;
    assign busy        = (state != ST_IDLE);

endmodule
